// File: rtl/adc_conv_sequencer_if.sv
// ADC pins plus averaged-sample stream bundle.
// master is the sequencer; slave is the ADC macro and sample consumer.
interface adc_conv_sequencer_if #(
  parameter int DATA_W = 14
);
  logic              adc_clk;
  logic              adc_start;
  logic              adc_ready;
  logic [DATA_W-1:0] adc_value;
  logic [3:0]        adc_counts;
  logic [DATA_W-1:0] adc_current;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output adc_clk,
    output adc_start,
    output adc_counts,
    output adc_current,
    output sample_valid,
    input  adc_ready,
    input  adc_value,
    input  sample_ready
  );

  modport slave (
    input  adc_clk,
    input  adc_start,
    input  adc_counts,
    input  adc_current,
    input  sample_valid,
    output adc_ready,
    output adc_value,
    output sample_ready
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// ADC conversion initiator: clock/start generation, ready capture,
// 2^AVG_LOG2 averaging and valid/ready delivery of the result.
module adc_conv_sequencer #(
  parameter int CLK_DIV  = 64,
  parameter int DATA_W   = 14,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clr_err,
  output logic timeout_err,
  adc_conv_sequencer_if.master bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF =
    DIV_W'(CLK_DIV / 2);
  localparam logic [TMO_W-1:0] TMO_MAX =
    TMO_W'(TIMEOUT);
  localparam logic [3:0] N_AVG =
    4'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_WAIT,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              run_q, run_d;
  logic              aclk_q, aclk_d;
  logic              start_q, start_d;
  logic [2:0]        sync_q, sync_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic              valid_q, valid_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic             want;
  logic             tick;
  logic             rdy_rise;
  logic             err_set;
  logic [ACC_W-1:0] acc_sum;
  logic [3:0]       cnt_inc;
  logic [TMO_W-1:0] tmo_inc;

  // A stopped divider restarts on a tick so
  // adc_clk always begins with a full high phase.
  always_comb begin
    want  = enable || (state_q != ST_IDLE);
    tick  = run_q ? (div_q == DIV_MAX) : want;
    run_d = run_q;
    div_d = div_q;
    if (tick) begin
      run_d = want;
      div_d = '0;
    end else if (run_q) begin
      div_d = div_q + 1'b1;
    end
    aclk_d = run_d && (div_d < DIV_HALF);
  end

  always_comb begin
    sync_d   = {sync_q[1:0], bus.adc_ready};
    rdy_rise = sync_q[1] && !sync_q[2];
    val_d    = rdy_rise ? bus.adc_value : val_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    acc_sum = acc_q + ACC_W'(val_q);
    cnt_inc = cnt_q + 4'd1;
    tmo_inc = tmo_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (tick && enable) state_d = ST_START;
      end
      ST_SYNC: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (tick) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (tick) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (rdy_rise) begin
          state_d = ST_ACCUM;
        end else if (tick) begin
          if (tmo_inc == TMO_MAX) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cnt_inc == N_AVG) begin
          cur_d   = DATA_W'(acc_sum >> AVG_LOG2);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_OUTPUT;
        end else begin
          acc_d   = acc_sum;
          cnt_d   = cnt_inc;
          state_d = ST_SYNC;
        end
      end
      ST_OUTPUT: begin
        if (bus.sample_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_START);
    valid_d = (state_d == ST_OUTPUT);
    err_d   = err_set ? 1'b1
            : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      run_q   <= 1'b0;
      aclk_q  <= 1'b0;
      start_q <= 1'b0;
      sync_q  <= '0;
      val_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      run_q   <= run_d;
      aclk_q  <= aclk_d;
      start_q <= start_d;
      sync_q  <= sync_d;
      val_q   <= val_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign bus.adc_clk      = aclk_q;
  assign bus.adc_start    = start_q;
  assign bus.adc_counts   = cnt_q;
  assign bus.adc_current  = cur_q;
  assign bus.sample_valid = valid_q;
  assign timeout_err      = err_q;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: ADC model, window-average
// scoreboard and directed scenarios.
module tb_adc_conv_sequencer;
  localparam int CLK_DIV  = 8;
  localparam int DATA_W   = 14;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 16;
  localparam int DLY      = 5;
  localparam int NWIN     = 1 << AVG_LOG2;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic enable  = 1'b0;
  logic clr_err = 1'b0;
  logic timeout_err;

  adc_conv_sequencer_if #(.DATA_W(DATA_W)) bus ();

  adc_conv_sequencer #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clr_err    (clr_err),
    .timeout_err(timeout_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endfunction

  int valq[$];
  int exp_q[$];
  int m_cnt      = 0;
  int m_sum      = 0;
  bit noready    = 1'b0;
  bit glitch     = 1'b0;
  bit chk_on     = 1'b1;
  int abort_req  = 0;
  int abort_seen = 0;

  // ADC macro: ready DLY adc_clk rises after start ends;
  // the window average each delivery implies is queued.
  initial begin : adc_model
    bit armed;
    bit st_p;
    bit ck_p;
    int n;
    int v;
    armed = 0; st_p = 0; ck_p = 0; n = 0; v = 0;
    bus.adc_ready = 1'b0;
    bus.adc_value = '0;
    forever begin
      @(posedge clk); #1;
      if (abort_req != abort_seen) begin
        abort_seen = abort_req;
        armed = 0;
        m_cnt = 0;
        m_sum = 0;
        valq.delete();
      end
      if (glitch) bus.adc_ready = 1'b0;
      if (bus.adc_start && !st_p) begin
        bus.adc_ready = 1'b0;
        armed = 0;
      end else if (!bus.adc_start && st_p) begin
        armed = rst_n && !noready;
        n = 0;
      end else if (armed && bus.adc_clk && !ck_p) begin
        n++;
        if (n == DLY) begin
          v = (valq.size() > 0) ? valq.pop_front() : 0;
          bus.adc_value = DATA_W'(v);
          bus.adc_ready = 1'b1;
          armed = 0;
          m_sum += v;
          m_cnt++;
          if (m_cnt == NWIN) begin
            exp_q.push_back(m_sum / NWIN);
            m_cnt = 0;
            m_sum = 0;
          end
        end
      end
      st_p = bus.adc_start;
      ck_p = bus.adc_clk;
    end
  end

  initial begin : compare
    bit pst, pck, pv, pr, perr;
    int st_w, ck_w, tk;
    int pcur;
    pst = 0; pck = 0; pv = 0; pr = 0; perr = 0;
    st_w = 0; ck_w = 0; tk = 0; pcur = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st_w = 0; ck_w = 0; tk = 0;
      end else begin
        if (bus.adc_clk && !pck) tk++;
        if (!bus.adc_start && pst) tk = 0;
        if (timeout_err && !perr)
          chk("tmo_ticks", tk, TIMEOUT);
        if (bus.adc_start) st_w++;
        if (bus.adc_start && !pst && chk_on)
          chk("counts_at_start", bus.adc_counts, m_cnt);
        if (!bus.adc_start && pst && chk_on)
          chk("start_width", st_w, CLK_DIV);
        if (!bus.adc_start) st_w = 0;
        if (bus.adc_clk) ck_w++;
        if (!bus.adc_clk && pck && chk_on)
          chk("clk_high_width", ck_w, CLK_DIV / 2);
        if (!bus.adc_clk) ck_w = 0;
        if (pv && pr)
          chk("valid_drop", bus.sample_valid, 0);
        if (bus.sample_valid && pv && !pr)
          chk("stall_hold", bus.adc_current, pcur);
        if (bus.sample_valid)
          chk("no_start_in_output", bus.adc_start, 0);
        if (bus.sample_valid && bus.sample_ready) begin
          if (exp_q.size() == 0)
            chk("unexpected_sample", bus.sample_valid, 0);
          else
            chk("avg_sample", bus.adc_current,
                exp_q.pop_front());
        end
      end
      pst  = bus.adc_start;
      pck  = bus.adc_clk;
      pv   = bus.sample_valid;
      pr   = bus.sample_ready;
      perr = timeout_err;
      pcur = bus.adc_current;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(string nm);
    int k;
    k = 0;
    while (!bus.sample_valid && k < 800) begin
      cyc(); k++;
    end
    chk(nm, bus.sample_valid, 1);
  endtask

  task automatic wait_start(string nm, bit lvl);
    int k;
    k = 0;
    while (bus.adc_start != lvl && k < 300) begin
      cyc(); k++;
    end
    chk(nm, bus.adc_start, lvl);
  endtask

  initial begin : main
    int k;
    int hi;
    bus.sample_ready = 1'b1;
    #12;
    chk("rst_adc_clk", bus.adc_clk, 0);
    chk("rst_adc_start", bus.adc_start, 0);
    chk("rst_counts", bus.adc_counts, 0);
    chk("rst_current", bus.adc_current, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_err", timeout_err, 0);
    cyc(); rst_n = 1'b1;
    cyc(2);
    valq = {100, 101, 102, 104,
            16383, 16383, 16383, 16383};
    enable = 1'b1;

    wait_valid("win1_valid");
    chk("win1_avg", bus.adc_current, 101);
    cyc();
    wait_valid("win_max_valid");
    chk("win_max_avg", bus.adc_current, 16383);
    cyc();

    bus.sample_ready = 1'b0;
    valq.push_back(8); valq.push_back(8);
    valq.push_back(8); valq.push_back(9);
    wait_valid("stall_valid");
    cyc(50);
    chk("stall_valid_held", bus.sample_valid, 1);
    chk("stall_avg", bus.adc_current, 8);
    chk("stall_no_start", bus.adc_start, 0);
    bus.sample_ready = 1'b1;
    cyc();
    chk("stall_release", bus.sample_valid, 0);
    k = 0;
    while (!bus.adc_start && k < 20) begin
      cyc(); k++;
    end
    chk("resume_start", bus.adc_start, 1);
    chk("resume_lat", int'(k <= CLK_DIV), 1);

    noready = 1'b1;
    k = 0;
    while (!timeout_err && k < 400) begin
      cyc(); k++;
    end
    chk("tmo_err", timeout_err, 1);
    chk("tmo_counts", bus.adc_counts, 0);
    cyc(3);
    chk("tmo_sticky", timeout_err, 1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("tmo_clr", timeout_err, 0);
    valq.push_back(200); valq.push_back(300);
    noready = 1'b0;
    wait_start("tmo_restart", 1'b1);

    k = 0;
    while (m_cnt != 2 && k < 600) begin
      cyc(); k++;
    end
    chk("drop_two_done", m_cnt, 2);
    wait_start("drop_start_hi", 1'b1);
    wait_start("drop_start_lo", 1'b0);
    cyc(2);
    enable = 1'b0;
    abort_req++;
    cyc();
    chk("drop_start", bus.adc_start, 0);
    chk("drop_counts", bus.adc_counts, 0);
    k = 0;
    while (bus.adc_clk && k < CLK_DIV) begin
      cyc(); k++;
    end
    chk("drop_clk_low", bus.adc_clk, 0);
    hi = 0;
    repeat (16) begin
      cyc();
      if (bus.adc_clk) hi++;
    end
    chk("drop_clk_stopped", hi, 0);
    valq.push_back(200); valq.push_back(300);
    valq.push_back(400); valq.push_back(501);
    enable = 1'b1;
    wait_valid("reen_valid");
    chk("reen_avg", bus.adc_current, 350);
    cyc();

    wait_start("rst_mid_start", 1'b1);
    cyc(3);
    chk_on = 1'b0;
    abort_req++;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", bus.adc_start, 0);
    chk("arst_clk", bus.adc_clk, 0);
    chk("arst_valid", bus.sample_valid, 0);
    chk("arst_current", bus.adc_current, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk_on = 1'b1;
    glitch = 1'b1;
    valq.push_back(1); valq.push_back(2);
    valq.push_back(3); valq.push_back(5);
    wait_valid("glitch_valid");
    chk("glitch_avg", bus.adc_current, 2);
    cyc(3);
    chk("exp_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Initiator side of the ADC conversion interface.
- Generates adc_clk and adc_start, waits for adc_ready, and captures adc_value.
- Averages 2^AVG_LOG2 conversions and presents the result as adc_current on a valid/ready stream to downstream logic.
- Sits between the ADC macro and the sample consumer; the debug capture taps the same adc_* nets it drives and receives.

Parameters:
CLK_DIV, 64, adc_clk period in clk cycles; even, >= 4
DATA_W, 14, ADC sample width
AVG_LOG2, 2, log2 of conversions averaged per output sample; 0..3
TIMEOUT, 1023, adc_clk periods allowed in WAIT before abort; >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run conversions continuously while high
adc_clk  out  1  ADC conversion clock, 50% duty
adc_start  out  1  conversion request to ADC
adc_ready  in  1  ADC conversion done; level, synchronised internally
adc_value  in  DATA_W  ADC result; stable while adc_ready high
adc_counts  out  4  conversions accumulated in current window
adc_current  out  DATA_W  averaged sample
sample_valid  out  1  adc_current valid
sample_ready  in  1  downstream accepts sample
timeout_err  out  1  sticky, set on WAIT timeout
clr_err  in  1  clears timeout_err

Behaviour:
- Reset (async, rst_n low): all outputs 0. FSM to IDLE. Divider, accumulator, timeout counter, synchroniser and adc_counts cleared.
- adc_clk generation:
  - Divider counts 0..CLK_DIV-1 while enable is high or FSM != IDLE.
  - adc_clk is high for counts 0..CLK_DIV/2-1, otherwise low.
  - adc_clk is held low with the divider at 0 when idle and enable is low.
  - "tick" = clk cycle where the divider wraps to 0 (adc_clk rising edge).
- adc_ready path: 2-flop synchroniser, then rising-edge detect (rdy_rise). Pin-to-rdy_rise latency is 3 clk cycles. adc_value is registered in the same cycle as rdy_rise.
- FSM:
  - IDLE: on tick with enable=1, go to START.
  - START: adc_start=1 for exactly CLK_DIV clk cycles, from a tick to the next tick; then go to WAIT and clear the timeout counter.
  - WAIT: on rdy_rise go to ACCUM. Otherwise the timeout counter increments on each tick. When it reaches TIMEOUT: set timeout_err, clear accumulator and adc_counts, go to IDLE.
  - ACCUM (1 cycle):
    - acc <= acc + captured value, with acc width DATA_W+AVG_LOG2 so it cannot overflow.
    - adc_counts++.
    - If the new count == 2^AVG_LOG2: adc_current <= new acc >> AVG_LOG2 (truncate), clear acc and adc_counts, go to OUTPUT.
    - Else go to START, which waits for the next tick before asserting adc_start.
  - OUTPUT: sample_valid=1 and adc_current held until sample_ready=1. In the handshake cycle sample_valid drops next clk, then go to IDLE.
- adc_current changes only on entry to OUTPUT; it holds its last value otherwise.
- enable deasserted in START/WAIT/ACCUM:
  - Abort next clk: adc_start=0, acc and adc_counts cleared, go to IDLE.
  - The divider finishes its current period, then stops low.
- enable deasserted in OUTPUT: the pending sample is still delivered.
- Simultaneous events:
  - rdy_rise and timeout in the same cycle: rdy_rise wins, no error.
  - clr_err and a timeout set in the same cycle: set wins.
  - sample_ready while sample_valid=0: ignored.
- adc_ready already high when entering WAIT: not accepted; a fresh rising edge is required.
- Throughput: no new conversion starts while OUTPUT is stalled (backpressure stalls the ADC).

Test Plan:
- CLK_DIV=8, AVG_LOG2=2, sample_ready tied 1, enable=1; ADC model raises ready 5 adc_clk after start with values 100,101,102,104 -> adc_counts 1,2,3 then 0; adc_current=101 (407>>2); sample_valid high for 1 clk; adc_start high exactly 8 clk each time.
- All four values 16383 (max) -> adc_current=16383, no overflow; acc clears for the next window.
- Model never asserts ready, TIMEOUT=16 -> timeout_err=1 after 16 ticks in WAIT, adc_counts=0, FSM restarts; pulse clr_err -> timeout_err=0.
- sample_ready held 0 for 50 clk after sample_valid -> adc_current and sample_valid stable, no adc_start pulses; release -> one handshake, conversions resume at the next tick.
- enable dropped while in WAIT after 2 accumulated conversions -> adc_start low, adc_counts=0, adc_clk stops low within 8 clk; re-enable -> a fresh 4-conversion window averages correctly.
- rst_n asserted mid-START -> adc_start, adc_clk, sample_valid, adc_current immediately 0; adc_ready glitch of 1 clk width still produces exactly one capture.
